// File: rtl/mux_sel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mux_sel_sequencer
//  Brief    : Turns two raw active-low push buttons into a legal 2-bit mux
//             select code (0, 1, 2). Each key is synchronised, debounced and
//             edge-detected; a three-state FSM steps forward (key_n[0]) or
//             backward (key_n[1]) on each press. Code 2'b11 is never emitted.
//  Options  : define SEL_AUTO_STEP_EN to add an auto-forward timer gated by
//             auto_en (AUTO_PERIOD cycles per step). Without the macro
//             auto_en is ignored and no timer exists.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_sel_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_PERIOD     = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] key_n,
  input  logic       auto_en,
  output logic [1:0] sel,
  output logic       sel_changed
);

  localparam int c_db_w = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10
  } sel_state_t;

  logic [1:0] w_press;      // one-cycle press pulse per key
  logic       w_fwd_req;
  logic       w_bwd_req;

  sel_state_t r_state;
  sel_state_t w_state_nxt;
  logic       r_changed;

  // --------------------------------------------------------------------------
  // Per-key input pipeline: synchroniser, debouncer, falling-edge detector
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      logic              r_sync1;
      logic              r_sync2;
      logic              r_db;
      logic              r_db_d;
      logic [c_db_w-1:0] r_cnt;

      // Two-flop synchroniser; idle level is released (1)
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync1 <= 1'b1;
          r_sync2 <= 1'b1;
        end else begin
          r_sync1 <= key_n[gi];
          r_sync2 <= r_sync1;
        end
      end

      // Accept a new level only after DEBOUNCE_CYCLES consecutive differing cycles
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_db  <= 1'b1;
          r_cnt <= '0;
        end else if (r_sync2 == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == c_db_last) begin
          r_db  <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      // Delayed copy of the debounced level for edge detection
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_db_d <= 1'b1;
        end else begin
          r_db_d <= r_db;
        end
      end

      // Press is the 1->0 edge of the debounced level; releases are ignored
      assign w_press[gi] = r_db_d & ~r_db;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Step requests (optional auto-forward timer)
  // --------------------------------------------------------------------------
  assign w_bwd_req = (w_press == 2'b10);

`ifdef SEL_AUTO_STEP_EN
  localparam int c_auto_w = $clog2(AUTO_PERIOD);
  localparam logic [c_auto_w-1:0] c_auto_last = c_auto_w'(AUTO_PERIOD - 1);

  logic [c_auto_w-1:0] r_auto_cnt;
  logic                w_auto_tick;
  logic                w_manual;

  // Any manual press pulse (even both at once) counts as manual activity
  assign w_manual    = |w_press;
  assign w_auto_tick = auto_en && (r_auto_cnt == c_auto_last);

  // Auto timer: restarts on tick, on manual activity, and while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_auto_cnt <= '0;
    end else if (!auto_en || w_manual || w_auto_tick) begin
      r_auto_cnt <= '0;
    end else begin
      r_auto_cnt <= r_auto_cnt + 1'b1;
    end
  end

  // Manual activity in the tick cycle swallows the auto step
  assign w_fwd_req = (w_press == 2'b01) | (w_auto_tick & ~w_manual);
`else
  logic w_unused_auto;
  localparam int c_unused_period = AUTO_PERIOD;

  assign w_unused_auto = auto_en;
  assign w_fwd_req     = (w_press == 2'b01);
`endif

  // --------------------------------------------------------------------------
  // Select FSM
  // --------------------------------------------------------------------------

  // Next-state: rotate forward or backward; both-pressed is masked upstream
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S0: begin
        if (w_fwd_req)      w_state_nxt = S1;
        else if (w_bwd_req) w_state_nxt = S2;
      end
      S1: begin
        if (w_fwd_req)      w_state_nxt = S2;
        else if (w_bwd_req) w_state_nxt = S0;
      end
      S2: begin
        if (w_fwd_req)      w_state_nxt = S0;
        else if (w_bwd_req) w_state_nxt = S1;
      end
      default: w_state_nxt = S0;
    endcase
  end

  // State register plus registered change pulse aligned with the new sel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S0;
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_changed <= (w_state_nxt != r_state);
    end
  end

  assign sel         = r_state;
  assign sel_changed = r_changed;

endmodule
`default_nettype wire

// File: doc/mux_sel_sequencer.md
# mux_sel_sequencer

- Upstream control stage for the 2-bit 3:1 multiplexer lab block.
- Turns two raw active-low push buttons into a clean 2-bit select code (0, 1, 2), which drives the mux `sel` input.
- Each button is synchronised, debounced and edge-detected; the three-state select FSM steps forward or backward on each press.
- The FSM never emits 2'b11, so downstream `case` decoders see only legal codes.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a key level change (10 ms at 50 MHz); minimum 1.
- `AUTO_PERIOD`, default 50000000: cycles between automatic forward steps; minimum 2; used only with `SEL_AUTO_STEP_EN`.

Ports:
- `clk` input 1: single clock; all state is rising-edge triggered.
- `rst_n` input 1: asynchronous, active-low reset.
- `key_n` input 2: raw buttons, 0 = pressed, asynchronous to `clk`.
  - `key_n[0]` steps forward.
  - `key_n[1]` steps backward.
- `auto_en` input 1: enables auto-stepping; ignored without the macro.
- `sel` output 2: select code to the mux, always 2'b00, 2'b01 or 2'b10.
- `sel_changed` output 1: one-cycle pulse, high in the first cycle a new `sel` value is visible.

## Operation

Reset (`rst_n` = 0, takes effect immediately):
- `sel` = 2'b00, `sel_changed` = 0.
- Synchroniser flops = 1, debounced levels = 1 (released), debounce and auto counters = 0.
- Reset mid-debounce discards partial counts.
- A key held through reset release is accepted as one press after a full debounce.

Per-key pipeline:
- Synchroniser: 2-flop synchroniser.
- Debounce counter: width `$clog2(DEBOUNCE_CYCLES+1)`.
  - While the synchronised level equals the debounced level, the counter clears.
  - While they differ, the counter increments.
  - When the counter equals `DEBOUNCE_CYCLES-1` and the levels still differ, the debounced level takes the synchronised value and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles is never accepted.
- Press pulse: the registered previous debounced level is 1 and the current debounced level is 0 (1→0 edge). Releases generate nothing.

Select FSM, states S0 = 2'b00, S1 = 2'b01, S2 = 2'b10:
- Forward press only: S0→S1→S2→S0.
- Backward press only: S0→S2→S1→S0.
- Both press pulses in the same cycle: no change, `sel_changed` stays 0.
- Illegal encoding (unreachable): next state S0.
- `sel_changed` is registered: set on the same edge that updates `sel`, cleared on the next edge.

## Timing

- Raw key fall to synchronised level: 2 edges.
- Debounced level update: edge 2+`DEBOUNCE_CYCLES` after the raw change.
- Press pulse: high during the following cycle (combinational from the debounced level and its delayed copy).
- `sel` and `sel_changed` update on edge 3+`DEBOUNCE_CYCLES`, so total latency is `DEBOUNCE_CYCLES`+3 edges.
- Maximum step rate: one step per cycle; a pulse can recur only after a release and a new press, each fully debounced.

## Configuration

- Macro: `SEL_AUTO_STEP_EN`.
- Defined:
  - An auto timer counts while `auto_en` = 1.
  - On reaching `AUTO_PERIOD-1` it produces a forward-step request and restarts at 0.
  - `auto_en` = 0 clears the timer.
  - Any accepted manual step, including simultaneous both-press, clears the timer.
  - Manual request in the same cycle as an auto tick: the manual request wins and the auto tick is dropped.
- Undefined:
  - No timer logic is synthesised.
  - `auto_en` remains a port but has no effect.
  - `AUTO_PERIOD` is unused.

## Test plan

Bench parameters: `DEBOUNCE_CYCLES` = 4, `AUTO_PERIOD` = 10.

- Reset, then hold `key_n` = 2'b11 for 50 cycles → `sel` = 2'b00 throughout and `sel_changed` never asserts.
- `key_n[0]` low from edge 0 and held → `sel` = 2'b01 and `sel_changed` = 1 for exactly one cycle after edge 7. Release and repeat twice → `sel` goes 2'b10, then 2'b00.
- From S0, press `key_n[1]` → `sel` = 2'b10. A 3-cycle low glitch on `key_n[0]` → no change.
- Both keys fall on the same cycle → no `sel` change, no pulse. `rst_n` asserted mid-debounce (cycle 3) → outputs 0 at once, and no press is taken from the aborted count.
- With `SEL_AUTO_STEP_EN` and `auto_en` = 1, no keys → `sel` advances 00→01→10→00, one step every 10 cycles. A manual backward press landing on an auto tick → only the backward step occurs, and the next auto step comes 10 cycles later.
